// File: rtl/bomb_ctrl.sv
// -----------------------------------------------------------------------------
// bomb_ctrl
//
// Purpose:
//   Consumer side of a player's bomb-drop interface. On a rising edge of the
//   drop request it snaps a bomb onto the 32 px tile grid, runs the fuse,
//   blast and cooldown timers, and publishes the two blast hit rectangles.
//   The movement blocks test these rectangles for kill/respawn. One instance
//   runs per player and is clocked once per video frame.
//
// Optional feature (compile-time macro):
//   BOMB_REMOTE_DET_EN - adds the 'detonate' input. A rising edge of detonate
//                        while the bomb is armed cuts the fuse short and
//                        detonates on the next frame.
//
// Ports:
//   frame_clk                       in   frame-rate clock (rising edge)
//   Reset                           in   asynchronous, active-high reset
//   detonate                        in   remote detonation (BOMB_REMOTE_DET_EN only)
//   bomb_drop                       in   drop request level from the player block
//   userX, userY        [9:0]       in   player sprite top-left position
//   bomb_armed                      out  high while the fuse is burning
//   exploding                       out  high while the blast is live
//   bombX, bombY        [9:0]       out  bomb tile top-left position
//   hitHX/HY/HXS/HYS    [9:0]       out  horizontal arm: origin X, origin Y, width, height
//   hitVX/VY/VXS/VYS    [9:0]       out  vertical arm:   origin X, origin Y, width, height
// -----------------------------------------------------------------------------
module bomb_ctrl #(
    parameter int unsigned FUSE_FRAMES     = 120,
    parameter int unsigned BLAST_FRAMES    = 30,
    parameter int unsigned COOLDOWN_FRAMES = 15,
    parameter int unsigned BLAST_RANGE     = 1,
    parameter int unsigned TILE            = 32,
    parameter int unsigned ORIGIN          = 32,
    parameter int unsigned PLAY_END_X      = 576,
    parameter int unsigned PLAY_END_Y      = 448,
    parameter int unsigned HALF_X          = 9,
    parameter int unsigned HALF_Y          = 13
) (
    input  logic       frame_clk,
    input  logic       Reset,
`ifdef BOMB_REMOTE_DET_EN
    input  logic       detonate,
`endif
    input  logic       bomb_drop,
    input  logic [9:0] userX,
    input  logic [9:0] userY,
    output logic       bomb_armed,
    output logic       exploding,
    output logic [9:0] bombX,
    output logic [9:0] bombY,
    output logic [9:0] hitHX,
    output logic [9:0] hitHY,
    output logic [9:0] hitHXS,
    output logic [9:0] hitHYS,
    output logic [9:0] hitVX,
    output logic [9:0] hitVY,
    output logic [9:0] hitVXS,
    output logic [9:0] hitVYS
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int unsigned RANGE_PX = BLAST_RANGE * TILE;
    localparam int unsigned TILE_SH  = $clog2(TILE);
    // Last tile index whose whole tile still fits inside the playfield.
    localparam int unsigned MAX_COL  = (PLAY_END_X - ORIGIN) / TILE - 1;
    localparam int unsigned MAX_ROW  = (PLAY_END_Y - ORIGIN) / TILE - 1;

    localparam logic [7:0] FUSE_LOAD  = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0] BLAST_LOAD = 8'(BLAST_FRAMES - 1);
    localparam logic [7:0] COOL_LOAD  = (COOLDOWN_FRAMES == 0) ? 8'd0
                                                               : 8'(COOLDOWN_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_EXPLODE  = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t     r_state;
    logic [7:0] r_timer;
    logic       r_drop_q;
    logic       r_bomb_armed;
    logic       r_exploding;
    logic [9:0] r_bombX;
    logic [9:0] r_bombY;
    logic [9:0] r_hitHX, r_hitHY, r_hitHXS, r_hitHYS;
    logic [9:0] r_hitVX, r_hitVY, r_hitVXS, r_hitVYS;

    // -------------------------------------------------------------------------
    // Edge detection of the request inputs
    // -------------------------------------------------------------------------
    logic w_drop_req;
    logic w_det_req;

    assign w_drop_req = bomb_drop & ~r_drop_q;

`ifdef BOMB_REMOTE_DET_EN
    logic r_det_q;

    assign w_det_req = detonate & ~r_det_q;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_det_q <= 1'b0;
        end else begin
            r_det_q <= detonate;
        end
    end
`else
    // Without the remote option the fuse can only expire on its own.
    assign w_det_req = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Tile snapping of the player centre (11-bit so the +HALF never wraps)
    // -------------------------------------------------------------------------
    logic [10:0] w_cx, w_cy;
    logic [10:0] w_col, w_row;
    logic [9:0]  w_snap_x, w_snap_y;

    // NOTE: every variable is given a value before any conditional update, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cx  = {1'b0, userX} + 11'(HALF_X);
        w_cy  = {1'b0, userY} + 11'(HALF_Y);
        w_col = 11'd0;
        w_row = 11'd0;

        // A centre left of / above the playfield snaps to the first tile.
        if (w_cx >= 11'(ORIGIN)) begin
            w_col = (w_cx - 11'(ORIGIN)) >> TILE_SH;
        end
        if (w_cy >= 11'(ORIGIN)) begin
            w_row = (w_cy - 11'(ORIGIN)) >> TILE_SH;
        end

        // Keep the whole tile inside the playfield.
        if (w_col > 11'(MAX_COL)) begin
            w_col = 11'(MAX_COL);
        end
        if (w_row > 11'(MAX_ROW)) begin
            w_row = 11'(MAX_ROW);
        end

        w_snap_x = 10'(11'(ORIGIN) + (w_col << TILE_SH));
        w_snap_y = 10'(11'(ORIGIN) + (w_row << TILE_SH));
    end

    // -------------------------------------------------------------------------
    // Blast arm extents, clipped to the playfield on both ends
    // -------------------------------------------------------------------------
    logic [10:0] w_bx, w_by;
    logic [10:0] w_hx, w_hend, w_hxs;
    logic [10:0] w_vy, w_vend, w_vys;

    always_comb begin
        w_bx = {1'b0, r_bombX};
        w_by = {1'b0, r_bombY};

        if (w_bx < 11'(ORIGIN + RANGE_PX)) begin
            w_hx = 11'(ORIGIN);
        end else begin
            w_hx = w_bx - 11'(RANGE_PX);
        end
        w_hend = w_bx + 11'(TILE + RANGE_PX);
        if (w_hend > 11'(PLAY_END_X)) begin
            w_hend = 11'(PLAY_END_X);
        end
        w_hxs = w_hend - w_hx;

        if (w_by < 11'(ORIGIN + RANGE_PX)) begin
            w_vy = 11'(ORIGIN);
        end else begin
            w_vy = w_by - 11'(RANGE_PX);
        end
        w_vend = w_by + 11'(TILE + RANGE_PX);
        if (w_vend > 11'(PLAY_END_Y)) begin
            w_vend = 11'(PLAY_END_Y);
        end
        w_vys = w_vend - w_vy;
    end

    // -------------------------------------------------------------------------
    // Bomb FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_timer      <= 8'd0;
            r_drop_q     <= 1'b0;
            r_bomb_armed <= 1'b0;
            r_exploding  <= 1'b0;
            r_bombX      <= 10'd0;
            r_bombY      <= 10'd0;
            r_hitHX      <= 10'd0;
            r_hitHY      <= 10'd0;
            r_hitHXS     <= 10'd0;
            r_hitHYS     <= 10'd0;
            r_hitVX      <= 10'd0;
            r_hitVY      <= 10'd0;
            r_hitVXS     <= 10'd0;
            r_hitVYS     <= 10'd0;
        end else begin
            r_drop_q <= bomb_drop;

            case (r_state)
                S_IDLE: begin
                    if (w_drop_req) begin
                        r_state      <= S_ARMED;
                        r_timer      <= FUSE_LOAD;
                        r_bombX      <= w_snap_x;
                        r_bombY      <= w_snap_y;
                        r_bomb_armed <= 1'b1;
                    end
                end

                S_ARMED: begin
                    // Remote detonation and natural expiry share one path, so
                    // a coincident edge behaves exactly like expiry.
                    if ((r_timer == 8'd0) || w_det_req) begin
                        r_state      <= S_EXPLODE;
                        r_timer      <= BLAST_LOAD;
                        r_bomb_armed <= 1'b0;
                        r_exploding  <= 1'b1;
                        // Rectangles are loaded on entry so they are valid in
                        // the very first EXPLODE cycle.
                        r_hitHX      <= 10'(w_hx);
                        r_hitHY      <= r_bombY;
                        r_hitHXS     <= 10'(w_hxs);
                        r_hitHYS     <= 10'(TILE);
                        r_hitVX      <= r_bombX;
                        r_hitVY      <= 10'(w_vy);
                        r_hitVXS     <= 10'(TILE);
                        r_hitVYS     <= 10'(w_vys);
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                S_EXPLODE: begin
                    if (r_timer == 8'd0) begin
                        r_exploding <= 1'b0;
                        r_hitHX     <= 10'd0;
                        r_hitHY     <= 10'd0;
                        r_hitHXS    <= 10'd0;
                        r_hitHYS    <= 10'd0;
                        r_hitVX     <= 10'd0;
                        r_hitVY     <= 10'd0;
                        r_hitVXS    <= 10'd0;
                        r_hitVYS    <= 10'd0;
                        if (COOLDOWN_FRAMES == 0) begin
                            r_state <= S_IDLE;
                            r_timer <= 8'd0;
                        end else begin
                            r_state <= S_COOLDOWN;
                            r_timer <= COOL_LOAD;
                        end
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                S_COOLDOWN: begin
                    if (r_timer == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_timer <= 8'd0;
                end
            endcase
        end
    end

    assign bomb_armed = r_bomb_armed;
    assign exploding  = r_exploding;
    assign bombX      = r_bombX;
    assign bombY      = r_bombY;
    assign hitHX      = r_hitHX;
    assign hitHY      = r_hitHY;
    assign hitHXS     = r_hitHXS;
    assign hitHYS     = r_hitHYS;
    assign hitVX      = r_hitVX;
    assign hitVY      = r_hitVY;
    assign hitVXS     = r_hitVXS;
    assign hitVYS     = r_hitVYS;

endmodule

// File: tb/tb_bomb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bomb_ctrl
//
// Self-checking bench for bomb_ctrl. A timeline model (cycles elapsed since
// the bomb was accepted) predicts every output each frame; directed steps
// pin the documented scenarios to constant values, and a random phase
// exercises drops anywhere on (and off) the playfield.
// -----------------------------------------------------------------------------
module tb_bomb_ctrl;

    localparam int FUSE  = 120;
    localparam int BLAST = 30;
    localparam int COOL  = 15;
    localparam int RANGE = 1;
    localparam int TILE  = 32;
    localparam int ORG   = 32;
    localparam int ENDX  = 576;
    localparam int ENDY  = 448;
    localparam int HX    = 9;
    localparam int HY    = 13;
    localparam int TOTAL = FUSE + BLAST + COOL;

`ifdef BOMB_REMOTE_DET_EN
    localparam bit REMOTE = 1'b1;
`else
    localparam bit REMOTE = 1'b0;
`endif

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b0;
    logic       bomb_drop = 1'b0;
    logic       detonate  = 1'b0;
    logic [9:0] userX     = 10'd0;
    logic [9:0] userY     = 10'd0;

    logic       bomb_armed, exploding;
    logic [9:0] bombX, bombY;
    logic [9:0] hitHX, hitHY, hitHXS, hitHYS;
    logic [9:0] hitVX, hitVY, hitVXS, hitVYS;

    bomb_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
`ifdef BOMB_REMOTE_DET_EN
        .detonate  (detonate),
`endif
        .bomb_drop (bomb_drop),
        .userX     (userX),
        .userY     (userY),
        .bomb_armed(bomb_armed),
        .exploding (exploding),
        .bombX     (bombX),
        .bombY     (bombY),
        .hitHX     (hitHX),
        .hitHY     (hitHY),
        .hitHXS    (hitHXS),
        .hitHYS    (hitHYS),
        .hitVX     (hitVX),
        .hitVY     (hitVY),
        .hitVXS    (hitVXS),
        .hitVYS    (hitVYS)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: age = frames since the bomb was accepted, -1 when idle.
    int m_age       = -1;
    bit m_prev_drop = 1'b0;
    bit m_prev_det  = 1'b0;
    int m_bx        = 0;
    int m_by        = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Tile top-left for a sprite coordinate: centre, tile index, clamp.
    function automatic int snap(int u, int half, int play_end);
        int c, idx, last;
        c    = u + half;
        last = (play_end - ORG) / TILE - 1;
        idx  = (c < ORG) ? 0 : (c - ORG) / TILE;
        if (idx > last) idx = last;
        return ORG + idx * TILE;
    endfunction

    task automatic check_model();
        bit e_arm, e_exp;
        int lo_x, hi_x, lo_y, hi_y;
        e_arm = (m_age >= 0) && (m_age < FUSE);
        e_exp = (m_age >= FUSE) && (m_age < FUSE + BLAST);
        lo_x  = imax(ORG, m_bx - RANGE * TILE);
        hi_x  = imin(m_bx + TILE + RANGE * TILE, ENDX);
        lo_y  = imax(ORG, m_by - RANGE * TILE);
        hi_y  = imin(m_by + TILE + RANGE * TILE, ENDY);
        chk("m_bomb_armed", 32'(bomb_armed), 32'(e_arm));
        chk("m_exploding",  32'(exploding),  32'(e_exp));
        chk("m_bombX",      32'(bombX),      32'(m_bx));
        chk("m_bombY",      32'(bombY),      32'(m_by));
        chk("m_hitHX",      32'(hitHX),      e_exp ? 32'(lo_x)        : 32'd0);
        chk("m_hitHY",      32'(hitHY),      e_exp ? 32'(m_by)        : 32'd0);
        chk("m_hitHXS",     32'(hitHXS),     e_exp ? 32'(hi_x - lo_x) : 32'd0);
        chk("m_hitHYS",     32'(hitHYS),     e_exp ? 32'(TILE)        : 32'd0);
        chk("m_hitVX",      32'(hitVX),      e_exp ? 32'(m_bx)        : 32'd0);
        chk("m_hitVY",      32'(hitVY),      e_exp ? 32'(lo_y)        : 32'd0);
        chk("m_hitVXS",     32'(hitVXS),     e_exp ? 32'(TILE)        : 32'd0);
        chk("m_hitVYS",     32'(hitVYS),     e_exp ? 32'(hi_y - lo_y) : 32'd0);
    endtask

    // One frame: advance the model on the edge, then compare 1 time unit later.
    task automatic step();
        bit req, dreq;
        @(posedge frame_clk);
        if (Reset) begin
            m_age       = -1;
            m_prev_drop = 1'b0;
            m_prev_det  = 1'b0;
            m_bx        = 0;
            m_by        = 0;
        end else begin
            req  = bomb_drop && !m_prev_drop;
            dreq = REMOTE && detonate && !m_prev_det;
            if (m_age < 0) begin
                if (req) begin
                    m_age = 0;
                    m_bx  = snap(int'(userX), HX, ENDX);
                    m_by  = snap(int'(userY), HY, ENDY);
                end
            end else begin
                if (m_age < FUSE && dreq) m_age = FUSE;
                else                      m_age++;
                if (m_age >= TOTAL) m_age = -1;
            end
            m_prev_drop = bomb_drop;
            m_prev_det  = detonate;
        end
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drop_at(input int x, input int y);
        userX     = 10'(x);
        userY     = 10'(y);
        bomb_drop = 1'b1;
        step();
        bomb_drop = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_armed"},  32'(bomb_armed), 32'd0);
        chk({tag, "_expl"},   32'(exploding),  32'd0);
        chk({tag, "_bombX"},  32'(bombX),      32'd0);
        chk({tag, "_bombY"},  32'(bombY),      32'd0);
        chk({tag, "_hitHX"},  32'(hitHX),      32'd0);
        chk({tag, "_hitHXS"}, 32'(hitHXS),     32'd0);
        chk({tag, "_hitVY"},  32'(hitVY),      32'd0);
        chk({tag, "_hitVYS"}, 32'(hitVYS),     32'd0);
    endtask

    initial begin
        int cnt_a, cnt_e;

        // ---------------- reset ----------------
        #1 Reset = 1'b1;
        #1 chk_all_zero("rst");
        step();
        #2 Reset = 1'b0;

        // ---------------- drop at 34,34: top-left corner ----------------
        drop_at(34, 34);
        chk("a_armed", 32'(bomb_armed), 32'd1);
        chk("a_bombX", 32'(bombX), 32'd32);
        chk("a_bombY", 32'(bombY), 32'd32);
        run(FUSE - 1);
        chk("a_still_armed", 32'(bomb_armed), 32'd1);
        step();
        chk("a_expl",   32'(exploding), 32'd1);
        chk("a_hitHX",  32'(hitHX),  32'd32);
        chk("a_hitHXS", 32'(hitHXS), 32'd64);
        chk("a_hitHY",  32'(hitHY),  32'd32);
        chk("a_hitHYS", 32'(hitHYS), 32'd32);
        chk("a_hitVX",  32'(hitVX),  32'd32);
        chk("a_hitVXS", 32'(hitVXS), 32'd32);
        chk("a_hitVY",  32'(hitVY),  32'd32);
        chk("a_hitVYS", 32'(hitVYS), 32'd64);
        run(BLAST + COOL);

        // ---------------- drop at 100,200: mid field, durations ----------------
        drop_at(100, 200);
        chk("b_bombX", 32'(bombX), 32'd96);
        chk("b_bombY", 32'(bombY), 32'd192);
        run(FUSE);
        chk("b_hitHX",  32'(hitHX),  32'd64);
        chk("b_hitHXS", 32'(hitHXS), 32'd96);
        chk("b_hitVY",  32'(hitVY),  32'd160);
        chk("b_hitVYS", 32'(hitVYS), 32'd96);
        cnt_e = exploding ? 1 : 0;
        for (int i = 0; i < BLAST - 1; i++) begin
            step();
            if (exploding) cnt_e++;
        end
        step();
        chk("b_expl_len", 32'(cnt_e), 32'(BLAST));
        chk("b_expl_end", 32'(exploding), 32'd0);
        // Last cooldown frame: an edge here lands on COOLDOWN->IDLE and is lost.
        run(COOL - 2);
        bomb_drop = 1'b1;
        step();
        step();
        chk("b_cool_ignore", 32'(bomb_armed), 32'd0);
        bomb_drop = 1'b0;
        step();
        drop_at(100, 200);
        chk("b_rearm", 32'(bomb_armed), 32'd1);
        run(TOTAL);

        // ---------------- drop at 550,420: right/bottom clamp ----------------
        drop_at(550, 420);
        chk("c_bombX", 32'(bombX), 32'd544);
        chk("c_bombY", 32'(bombY), 32'd416);
        run(FUSE);
        chk("c_hitHX",  32'(hitHX),  32'd512);
        chk("c_hitHXS", 32'(hitHXS), 32'd64);
        chk("c_hitVY",  32'(hitVY),  32'd384);
        chk("c_hitVYS", 32'(hitVYS), 32'd64);
        run(BLAST + COOL + 2);

        // ---------------- held drop: exactly one bomb ----------------
        userX = 10'd200;
        userY = 10'd100;
        bomb_drop = 1'b1;
        cnt_a = 0;
        cnt_e = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bomb_armed) cnt_a++;
            if (exploding)  cnt_e++;
        end
        chk("d_held_armed", 32'(cnt_a), 32'(FUSE));
        chk("d_held_expl",  32'(cnt_e), 32'(BLAST));
        bomb_drop = 1'b0;
        step();
        drop_at(200, 100);
        chk("d_rearm", 32'(bomb_armed), 32'd1);
        run(5);
        // A second edge while armed must not move the bomb.
        drop_at(400, 300);
        chk("d_ign_bombX", 32'(bombX), 32'd192);
        chk("d_ign_bombY", 32'(bombY), 32'd96);
        run(TOTAL);

        // ---------------- random drops across the whole coordinate range ----------------
        for (int i = 0; i < 3000; i++) begin
            userX = 10'($urandom_range(0, 1023));
            userY = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) bomb_drop = ~bomb_drop;
            if ($urandom_range(0, 15) == 0) detonate = ~detonate;
            step();
        end
        bomb_drop = 1'b0;
        detonate  = 1'b0;
        run(TOTAL + 2);

        // ---------------- reset in the middle of the fuse ----------------
        drop_at(300, 250);
        run(59);
        chk("e_armed_pre", 32'(bomb_armed), 32'd1);
        #2 Reset = 1'b1;
        #1 chk_all_zero("e_async");
        step();
        #2 Reset = 1'b0;
        cnt_e = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (exploding || bomb_armed) cnt_e++;
        end
        chk("e_no_blast", 32'(cnt_e), 32'd0);

`ifdef BOMB_REMOTE_DET_EN
        // ---------------- remote detonation ----------------
        drop_at(150, 150);
        run(9);
        detonate = 1'b1;
        step();
        chk("f_det_expl", 32'(exploding), 32'd1);
        detonate = 1'b0;
        cnt_e = 1;
        for (int i = 0; i < BLAST; i++) begin
            step();
            if (exploding) cnt_e++;
        end
        chk("f_det_len", 32'(cnt_e), 32'(BLAST));
        run(COOL + 2);
        detonate = 1'b1;
        step();
        step();
        chk("f_idle_det", 32'(exploding | bomb_armed), 32'd0);
        detonate = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bomb_ctrl.md
Name: bomb_ctrl

Overview:
Consumer side of the player's bomb-drop interface. Takes a player's bomb_drop request and position, snaps a bomb to the 32 px tile grid, runs the fuse and blast timers, then publishes the blast hit rectangles. The player/opponent movement blocks use these rectangles for their kill/respawn check. One instance per player, clocked once per video frame.

Parameters:
FUSE_FRAMES, 120, frames spent armed before detonation (1..255)
BLAST_FRAMES, 30, frames the blast rectangles are live (1..255)
COOLDOWN_FRAMES, 15, frames after blast before a new drop is accepted (0..255)
BLAST_RANGE, 1, blast arm length in tiles on each side of the bomb tile (0..3)
TILE, 32, tile size in px
ORIGIN, 32, playfield top-left X and Y in px
PLAY_END_X, 576, exclusive right playfield bound in px
PLAY_END_Y, 448, exclusive bottom playfield bound in px
HALF_X, 9, player sprite half width used for centre snapping
HALF_Y, 13, player sprite half height used for centre snapping

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  asynchronous, active-high reset
bomb_drop  in  1  drop request level from the player block
userX  in  10  player sprite top-left X
userY  in  10  player sprite top-left Y
bomb_armed  out  1  high in ARMED
exploding  out  1  high in EXPLODE
bombX  out  10  bomb tile top-left X
bombY  out  10  bomb tile top-left Y
hitHX, hitHY, hitHXS, hitHYS  out  10 each  horizontal blast arm: origin X, origin Y, width, height
hitVX, hitVY, hitVXS, hitVYS  out  10 each  vertical blast arm: origin X, origin Y, width, height

Behaviour:
- Reset is asynchronous, active-high. Clock is frame_clk. All registers are rising-edge.
- Reset values: state IDLE, timer 0, drop_q 0. All outputs are 0. Reset asserted mid-fuse or mid-blast aborts immediately; there is no deferred detonation.
- Drop edge: drop_q registers bomb_drop every cycle. A request is bomb_drop & ~drop_q. A held key places at most one bomb.
- States: IDLE, ARMED, EXPLODE, COOLDOWN.
- IDLE -> ARMED on a request edge.
  - Column col = (userX+HALF_X-ORIGIN)>>5. Row row = (userY+HALF_Y-ORIGIN)>>5.
  - If a centre coordinate is below ORIGIN, the index is 0. Indices are clamped so the tile lies inside the playfield.
  - bombX = ORIGIN+col*TILE and bombY = ORIGIN+row*TILE are latched on the same edge. timer loads FUSE_FRAMES-1.
- ARMED: timer decrements each edge. When timer==0, go to EXPLODE and load timer with BLAST_FRAMES-1. ARMED lasts exactly FUSE_FRAMES cycles.
- EXPLODE: same countdown. At timer==0, go to COOLDOWN and load COOLDOWN_FRAMES-1. If COOLDOWN_FRAMES==0, go straight to IDLE.
- COOLDOWN: same countdown, then IDLE.
- Request edges outside IDLE are ignored, not queued. bomb_drop held across the COOLDOWN->IDLE transition does not re-trigger, because no new edge occurs.
- bombX/bombY hold their values until the next accepted drop.
- Hit rectangles are registered and valid in every EXPLODE cycle. They are all zero in every other state, so size 0 never matches a hit test.
- Horizontal arm:
  - hitHX = ORIGIN if bombX < ORIGIN+BLAST_RANGE*TILE, else bombX-BLAST_RANGE*TILE.
  - hitHXS = min(bombX+TILE+BLAST_RANGE*TILE, PLAY_END_X) - hitHX.
  - hitHY = bombY, hitHYS = TILE.
- Vertical arm: same rule on Y with PLAY_END_Y; hitVX = bombX, hitVXS = TILE.
- Arithmetic is 10-bit unsigned. Intermediate sums use 11 bits before clamping, so there is no wrap.

Optional Feature:
BOMB_REMOTE_DET_EN:
- Defined: adds input port detonate (1 bit). A rising edge of detonate (registered like bomb_drop) while in ARMED forces EXPLODE on the next edge, with timer loaded BLAST_FRAMES-1. Edges in other states are ignored. If the edge coincides with timer==0 in ARMED, the result is identical to normal expiry.
- Undefined: the port does not exist and the fuse always runs the full FUSE_FRAMES.

Test Plan:
- Reset, then userX=34, userY=34, bomb_drop pulse -> next edge: bomb_armed=1, bombX=32, bombY=32. After 120 cycles: exploding=1, hitHX=32, hitHXS=64, hitHY=32, hitHYS=32, hitVX=32, hitVXS=32, hitVY=32, hitVYS=64.
- userX=100, userY=200 drop -> bombX=96, bombY=192. In EXPLODE: hitHX=64, hitHXS=96, hitVY=160, hitVYS=96. exploding lasts exactly 30 cycles, then 15 cycles COOLDOWN, then IDLE.
- userX=550, userY=420 drop -> bombX=544, bombY=416. In EXPLODE: hitHX=512, hitHXS=64, hitVY=384, hitVYS=64 (right and bottom clamp).
- bomb_drop held high for 300 cycles -> exactly one bomb cycle (120+30+15). No second arm until bomb_drop falls and rises again. A second edge during ARMED changes nothing.
- Reset asserted at fuse cycle 60 -> all outputs 0 asynchronously. After release, the block stays IDLE and no explosion occurs.
- BOMB_REMOTE_DET_EN: drop, then detonate edge at armed cycle 10 -> exploding=1 on the following edge for 30 cycles. A detonate edge in IDLE has no effect.
